mem_wr_stage: RTL and testbench
===============================

MEM_WR_STAGE -- requirements
Module: mem_wr_stage

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 Port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1 bit: asynchronous active-high reset.
REQ-004 Port exmem_reg, input, 128 bits: [31:0] instr, [63:32] PC+4, [95:64] ALU result/address, [127:96] store data.
REQ-005 Port exmem_valid, input, 1 bit: exmem_reg holds a live instruction.
REQ-006 Port flush, input, 1 bit: kill the incoming exmem_reg instruction.
REQ-007 Port mem_req, output, 1 bit: data-memory access request.
REQ-008 Port mem_we, output, 1 bit: the request is a write.
REQ-009 Port mem_addr, output, 32 bits: word address, equal to {addr[31:2],2'b00}.
REQ-010 Port mem_be, output, 4 bits: byte enables.
REQ-011 Port mem_wdata, output, 32 bits: write data.
REQ-012 Port mem_rdata, input, 32 bits: read data, valid when mem_ready=1.
REQ-013 Port mem_ready, input, 1 bit: the access completes this cycle.
REQ-014 Port memwr_reg, output, 128 bits: [31:0] instr, [63:32] PC+4, [95:64] ALU result, [127:96] load data (0 for non-loads).
REQ-015 Port memwr_valid, output, 1 bit: memwr_reg holds a live instruction.
REQ-016 Port stall_out, output, 1 bit: freeze the upstream pipeline registers.
REQ-017 Port mem_err, output, 1 bit: sticky memory-timeout flag.

Function
REQ-018 Opcode op=instr[31:26]; loads are 100011 lw, 100000 lb, 100100 lbu; stores are 101011 sw, 101000 sb; every other opcode is a non-memory instruction.
REQ-019 The FSM SHALL have two states, IDLE and WAIT; the reset state is IDLE.
REQ-020 In IDLE, live = exmem_valid & !flush.
REQ-021 In IDLE with live and a non-memory op, the stage SHALL load memwr_reg at the next edge with memwr_valid=1 (latency 1), and mem_req=0.
REQ-022 In IDLE with live and a memory op, the stage SHALL drive mem_req=1 combinationally from exmem_reg.
REQ-023 If mem_ready=1 in the same cycle, the stage SHALL capture at the edge with memwr_valid=1 and stay in IDLE.
REQ-024 If mem_ready=0 in the same cycle, the stage SHALL assert stall_out=1 combinationally, latch exmem_reg into a hold register, and move to WAIT.
REQ-025 In WAIT, the stage SHALL drive mem_req, mem_we, mem_addr, mem_be and mem_wdata from the hold register, stable until mem_ready.
REQ-026 In WAIT, stall_out SHALL be 1 and memwr_valid SHALL be 0 each cycle (bubble).
REQ-027 In WAIT with mem_ready=1, the stage SHALL capture the result, set memwr_valid=1 at the edge, deassert stall_out in that cycle, and return to IDLE.
REQ-028 flush SHALL be ignored in WAIT; an access already issued always completes.
REQ-029 If the IDLE input is not live, memwr_reg SHALL become all-zero and memwr_valid 0 at the next edge.
REQ-030 lw SHALL drive mem_be=1111 and return rdata unchanged.
REQ-031 lb/lbu SHALL drive mem_be=1111 and select byte addr[1:0] (0 = rdata[7:0] ... 3 = rdata[31:24]); lb sign-extends, lbu zero-extends.
REQ-032 sw SHALL drive mem_be=1111 with wdata = store data.
REQ-033 sb SHALL drive mem_be=(0001<<addr[1:0]) with wdata = store data[7:0] replicated into all four bytes.
REQ-034 For non-loads, memwr_reg[127:96] SHALL be 0.
REQ-035 mem_we SHALL be 0 and mem_be SHALL be 0000 whenever mem_req=0.
REQ-036 An 8-bit wait counter SHALL clear on entering WAIT and increment each WAIT cycle.
REQ-037 When the wait counter reaches 255, the stage SHALL set mem_err=1 (sticky until reset) and keep waiting.
REQ-038 Back-to-back memory ops that each get same-cycle mem_ready SHALL produce one memwr_valid per cycle with no stall.

Reset
REQ-039 While rst=1: state=IDLE, memwr_reg=0, memwr_valid=0, hold register=0, wait counter=0, mem_err=0, and stall_out=mem_req=mem_we=0 with mem_be=0000; this takes effect immediately, asynchronous to clk.
REQ-040 A reset asserted during WAIT SHALL abandon the access, with mem_req=0 in that same cycle.

Verification
REQ-041 addu instr=0x00221821, ALU result=5, valid -> next cycle memwr_valid=1, [95:64]=5, [127:96]=0, mem_req never asserted.
REQ-042 lb at addr 0x1003, rdata=0x80FF_0000, mem_ready held low 3 cycles -> stall_out=1 and memwr_valid=0 for those 3 cycles, then [127:96]=0xFFFFFF80; for lbu the same stimulus -> 0x00000080.
REQ-043 sb at addr 0x2002 with store data 0x123456AB, same-cycle ready -> mem_we=1, mem_be=0100, mem_wdata=0xABABABAB, mem_addr=0x2000.
REQ-044 flush=1 with valid lw in IDLE -> mem_req=0, next memwr_valid=0; flush=1 during WAIT -> access still completes with memwr_valid=1.
REQ-045 mem_ready held low 256 cycles -> mem_err=1 after 255 WAIT cycles and stays 1 after completion; rst pulse mid-WAIT -> all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/mem_wr_stage.sv
// mem_wr_stage: MEM pipeline stage issuing data-memory accesses, stalling on wait states, building MEM/WB.
module mem_wr_stage (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] exmem_reg,
  input  logic         exmem_valid,
  input  logic         flush,
  output logic         mem_req,
  output logic         mem_we,
  output logic [31:0]  mem_addr,
  output logic [3:0]   mem_be,
  output logic [31:0]  mem_wdata,
  input  logic [31:0]  mem_rdata,
  input  logic         mem_ready,
  output logic [127:0] memwr_reg,
  output logic         memwr_valid,
  output logic         stall_out,
  output logic         mem_err
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, state_n;
  logic [127:0] hold, cur;
  logic [7:0] cnt, byte_sel;
  logic [5:0] op;
  logic [31:0] addr, ld;
  logic is_lw, is_lb, is_lbu, is_sw, is_sb, is_ld, is_st, live, done;
  always_comb begin
    cur = (state == WAIT) ? hold : exmem_reg;
    op = cur[31:26];
    addr = cur[95:64];
    is_lw = op == 6'b100011;
    is_lb = op == 6'b100000;
    is_lbu = op == 6'b100100;
    is_sw = op == 6'b101011;
    is_sb = op == 6'b101000;
    is_ld = is_lw | is_lb | is_lbu;
    is_st = is_sw | is_sb;
    live = exmem_valid & ~flush;
    mem_req = ~rst & ((state == WAIT) | (live & (is_ld | is_st)));
    mem_we = mem_req & is_st;
    mem_be = ~mem_req ? 4'b0000 : is_sb ? 4'b0001 << addr[1:0] : 4'b1111;
    mem_addr = mem_req ? {addr[31:2], 2'b00} : 32'h0;
    mem_wdata = ~mem_we ? 32'h0 : is_sb ? {4{cur[103:96]}} : cur[127:96];
    stall_out = mem_req & ~mem_ready;
    byte_sel = mem_rdata[{addr[1:0], 3'b000} +: 8];
    ld = is_lw ? mem_rdata : is_lb ? {{24{byte_sel[7]}}, byte_sel} : is_lbu ? {24'h0, byte_sel} : 32'h0;
    done = (mem_req & mem_ready) | ((state == IDLE) & live & ~is_ld & ~is_st);
    state_n = stall_out ? WAIT : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      hold <= '0;
      cnt <= '0;
      memwr_reg <= '0;
      memwr_valid <= 1'b0;
      mem_err <= 1'b0;
    end else begin
      state <= state_n;
      memwr_valid <= done;
      memwr_reg <= done ? {ld, cur[95:0]} : 128'h0;
      if (state == IDLE && stall_out) begin
        hold <= exmem_reg;
        cnt <= '0;
      end else if (state == WAIT)
        cnt <= cnt + {7'h0, cnt != 8'hff};
      // the 255th WAIT cycle trips the timeout; the access itself keeps waiting
      if (state == WAIT && cnt == 8'hfe) mem_err <= 1'b1;
    end
endmodule

// File: tb/tb_mem_wr_stage.sv
// tb_mem_wr_stage: table-driven single-cycle vectors plus stall, timeout and reset sequences.
module tb_mem_wr_stage;
  logic clk = 0, rst = 1;
  logic [127:0] exmem_reg = '0;
  logic exmem_valid = 0, flush = 0, mem_ready = 0;
  logic [31:0] mem_rdata = '0;
  logic mem_req, mem_we, memwr_valid, stall_out, mem_err;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0] mem_be;
  logic [127:0] memwr_reg;
  int n_chk = 0, n_fail = 0;

  mem_wr_stage dut (.clk(clk), .rst(rst), .exmem_reg(exmem_reg), .exmem_valid(exmem_valid),
    .flush(flush), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .memwr_reg(memwr_reg),
    .memwr_valid(memwr_valid), .stall_out(stall_out), .mem_err(mem_err));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr, pc4, alu, sd, rdata;
    logic valid, fl, rdy;
    logic e_req, e_we;
    logic [3:0] e_be;
    logic [31:0] e_addr, e_wdata;
    logic e_stall, e_v;
    logic [31:0] e_ld;
  } vec_t;
  vec_t vec [11];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] instr, pc4, alu, sd, input logic v, fl);
    exmem_reg = {sd, alu, pc4, instr};
    exmem_valid = v;
    flush = fl;
  endtask

  task automatic check_outs_zero(input string tag);
    check({tag, " req"}, mem_req, 0);
    check({tag, " we"}, mem_we, 0);
    check({tag, " be"}, mem_be, 0);
    check({tag, " stall"}, stall_out, 0);
    check({tag, " mwv"}, memwr_valid, 0);
    check({tag, " mwr"}, memwr_reg, 0);
    check({tag, " err"}, mem_err, 0);
  endtask

  task automatic stall_seq(input logic [31:0] instr, input logic [31:0] exp_ld, input string tag);
    @(negedge clk);
    drive(instr, 32'h40, 32'h1003, 32'h0, 1, 0);
    mem_ready = 0;
    mem_rdata = 32'h0;
    #1;
    check({tag, " issue req"}, mem_req, 1);
    check({tag, " issue stall"}, stall_out, 1);
    @(posedge clk); #1;
    check({tag, " issue mwv"}, memwr_valid, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(32'hACFF0000, 32'h0, 32'h7777, 32'h0, i == 0, i == 1);
      #1;
      check({tag, " wait stall"}, stall_out, 1);
      check({tag, " wait addr"}, mem_addr, 32'h1000);
      check({tag, " wait be"}, mem_be, 4'hf);
      check({tag, " wait we"}, mem_we, 0);
      @(posedge clk); #1;
      check({tag, " wait mwv"}, memwr_valid, 0);
    end
    @(negedge clk);
    drive(32'h0, 32'h0, 32'h0, 32'h0, 0, 1);
    mem_ready = 1;
    mem_rdata = 32'h80FF0000;
    #1;
    check({tag, " done stall"}, stall_out, 0);
    check({tag, " done req"}, mem_req, 1);
    @(posedge clk); #1;
    check({tag, " done mwv"}, memwr_valid, 1);
    check({tag, " done mwr"}, memwr_reg, {exp_ld, 32'h1003, 32'h40, instr});
    @(negedge clk);
    drive(32'h0, 32'h0, 32'h0, 32'h0, 0, 0);
  endtask

  initial begin
    vec[0]  = '{32'h00221821, 32'h04, 32'h0005, 32'h0,        32'h0,        1, 0, 0, 0, 0, 4'h0, 32'h0,    32'h0,        0, 1, 32'h0};
    vec[1]  = '{32'hA1020000, 32'h08, 32'h2002, 32'h123456AB, 32'h0,        1, 0, 1, 1, 1, 4'h4, 32'h2000, 32'hABABABAB, 0, 1, 32'h0};
    vec[2]  = '{32'hAC430008, 32'h0C, 32'h3005, 32'hDEADBEEF, 32'h0,        1, 0, 1, 1, 1, 4'hf, 32'h3004, 32'hDEADBEEF, 0, 1, 32'h0};
    vec[3]  = '{32'h8C440000, 32'h10, 32'h0100, 32'h0,        32'hCAFEF00D, 1, 0, 1, 1, 0, 4'hf, 32'h0100, 32'h0,        0, 1, 32'hCAFEF00D};
    vec[4]  = '{32'h80450000, 32'h14, 32'h1001, 32'h0,        32'h11228344, 1, 0, 1, 1, 0, 4'hf, 32'h1000, 32'h0,        0, 1, 32'hFFFFFF83};
    vec[5]  = '{32'h90460000, 32'h18, 32'h1002, 32'h0,        32'h11228344, 1, 0, 1, 1, 0, 4'hf, 32'h1000, 32'h0,        0, 1, 32'h00000022};
    vec[6]  = '{32'h80470000, 32'h1C, 32'h1000, 32'h0,        32'h1122837F, 1, 0, 1, 1, 0, 4'hf, 32'h1000, 32'h0,        0, 1, 32'h0000007F};
    vec[7]  = '{32'h8C480000, 32'h20, 32'h0200, 32'h0,        32'h00000055, 1, 1, 1, 0, 0, 4'h0, 32'h0,    32'h0,        0, 0, 32'h0};
    vec[8]  = '{32'hAC490000, 32'h24, 32'h0300, 32'hAA,      32'h0,        0, 0, 1, 0, 0, 4'h0, 32'h0,    32'h0,        0, 0, 32'h0};
    vec[9]  = '{32'hA04A0000, 32'h28, 32'h2003, 32'hCD,      32'h0,        1, 0, 1, 1, 1, 4'h8, 32'h2000, 32'hCDCDCDCD, 0, 1, 32'h0};
    vec[10] = '{32'h904B0000, 32'h2C, 32'h2003, 32'h0,        32'hF0000000, 1, 0, 1, 1, 0, 4'hf, 32'h2000, 32'h0,        0, 1, 32'h000000F0};

    drive(32'h8C440000, 32'h10, 32'h100, 32'h0, 1, 0);
    mem_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    check_outs_zero("reset");
    @(negedge clk);
    rst = 0;
    drive(32'h0, 32'h0, 32'h0, 32'h0, 0, 0);

    foreach (vec[k]) begin
      @(negedge clk);
      drive(vec[k].instr, vec[k].pc4, vec[k].alu, vec[k].sd, vec[k].valid, vec[k].fl);
      mem_rdata = vec[k].rdata;
      mem_ready = vec[k].rdy;
      #1;
      check($sformatf("v%0d req", k), mem_req, vec[k].e_req);
      check($sformatf("v%0d we", k), mem_we, vec[k].e_we);
      check($sformatf("v%0d be", k), mem_be, vec[k].e_be);
      check($sformatf("v%0d stall", k), stall_out, vec[k].e_stall);
      if (vec[k].e_req) check($sformatf("v%0d addr", k), mem_addr, vec[k].e_addr);
      if (vec[k].e_we) check($sformatf("v%0d wdata", k), mem_wdata, vec[k].e_wdata);
      @(posedge clk); #1;
      check($sformatf("v%0d mwv", k), memwr_valid, vec[k].e_v);
      check($sformatf("v%0d mwr", k), memwr_reg,
            vec[k].e_v ? {vec[k].e_ld, vec[k].alu, vec[k].pc4, vec[k].instr} : 128'h0);
    end

    stall_seq(32'h80450000, 32'hFFFFFF80, "lb");
    stall_seq(32'h90460000, 32'h00000080, "lbu");

    @(negedge clk);
    drive(32'hAC430000, 32'h50, 32'h4000, 32'h99, 1, 0);
    mem_ready = 0;
    @(posedge clk);
    for (int i = 1; i <= 256; i++) begin
      @(negedge clk);
      drive(32'h0, 32'h0, 32'h0, 32'h0, 0, 0);
      @(posedge clk); #1;
      if (i == 254) check("tmo err before", mem_err, 0);
      if (i == 255) check("tmo err at 255", mem_err, 1);
      if (i == 255) check("tmo still stalling", stall_out, 1);
    end
    @(negedge clk);
    mem_ready = 1;
    #1;
    check("tmo done we", mem_we, 1);
    check("tmo done wdata", mem_wdata, 32'h99);
    @(posedge clk); #1;
    check("tmo done mwv", memwr_valid, 1);
    check("tmo err sticky", mem_err, 1);

    @(negedge clk);
    drive(32'h8C440000, 32'h60, 32'h500, 32'h0, 1, 0);
    mem_ready = 0;
    @(posedge clk);
    @(negedge clk);
    drive(32'h0, 32'h0, 32'h0, 32'h0, 0, 0);
    #1;
    check("pre-rst wait req", mem_req, 1);
    #1;
    rst = 1;
    #1;
    check_outs_zero("mid-wait rst");
    @(negedge clk);
    rst = 0;
    drive(32'h00221821, 32'h70, 32'h9, 32'h0, 1, 0);
    #1;
    check("post-rst idle req", mem_req, 0);
    check("post-rst idle stall", stall_out, 0);
    @(posedge clk); #1;
    check("post-rst mwv", memwr_valid, 1);
    check("post-rst mwr", memwr_reg, {32'h0, 32'h9, 32'h70, 32'h00221821});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
